// File: rtl/mips_control_signal_alu_sequencer_pkg.sv
// Shared encodings for the registered ALU control sequencer: category flag
// positions, data-2 sources, ALU operations, MIPS opcode/funct values, states.
package mips_control_signal_alu_sequencer_pkg;

  localparam int CAT_SHIFT    = 0;
  localparam int CAT_SHIFTV   = 1;
  localparam int CAT_LOAD     = 2;
  localparam int CAT_STORE    = 3;
  localparam int CAT_REGISTER = 4;
  localparam int CAT_BRANCH   = 5;
  localparam int CAT_MULT     = 6;
  localparam int CAT_DIV      = 7;

  typedef enum logic [1:0] {
    D2_REGISTER  = 2'd0,
    D2_IMMEDIATE = 2'd1,
    D2_SHAMT     = 2'd2
  } data2_src_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOR   = 4'd5,
    ALU_SLT   = 4'd6,
    ALU_SLTU  = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_LUI   = 4'd11,
    ALU_MULT  = 4'd12,
    ALU_MULTU = 4'd13,
    ALU_DIV   = 4'd14,
    ALU_DIVU  = 4'd15
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mips_control_signal_alu_decode.sv
// Pure combinational map from opFunc/category to data-2 source, ALU operation
// and the mult/div path selects (Div wins when both flags are set).
module mips_control_signal_alu_decode
  import mips_control_signal_alu_sequencer_pkg::*;
#(
  parameter int OPFUNC_W   = 12,
  parameter int CATEGORY_W = 8,
  parameter int ALU_OP_W   = 4
) (
  input  logic [OPFUNC_W-1:0]   opFunc,
  input  logic [CATEGORY_W-1:0] category,
  output logic [1:0]            data2_source,
  output logic [ALU_OP_W-1:0]   alu_op,
  output logic                  is_mult,
  output logic                  is_div
);

  logic [5:0] opcode;
  logic [5:0] funct;
  alu_op_e    op;

  assign opcode = opFunc[OPFUNC_W-1 -: 6];
  assign funct  = opFunc[5:0];

  always_comb begin
    data2_source = D2_IMMEDIATE;
    if (category[CAT_SHIFT] && !category[CAT_SHIFTV])
      data2_source = D2_SHAMT;
    else if (category[CAT_LOAD] || category[CAT_STORE])
      data2_source = D2_IMMEDIATE;
    else if (category[CAT_REGISTER] || category[CAT_BRANCH] ||
             category[CAT_MULT] || category[CAT_DIV])
      data2_source = D2_REGISTER;
  end

  always_comb begin
    op = ALU_ADD;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_SLL, FN_SLLV:  op = ALU_SLL;
        FN_SRL, FN_SRLV:  op = ALU_SRL;
        FN_SRA, FN_SRAV:  op = ALU_SRA;
        FN_MULT:          op = ALU_MULT;
        FN_MULTU:         op = ALU_MULTU;
        FN_DIV:           op = ALU_DIV;
        FN_DIVU:          op = ALU_DIVU;
        FN_ADD, FN_ADDU:  op = ALU_ADD;
        FN_SUB, FN_SUBU:  op = ALU_SUB;
        FN_AND:           op = ALU_AND;
        FN_OR:            op = ALU_OR;
        FN_XOR:           op = ALU_XOR;
        FN_NOR:           op = ALU_NOR;
        FN_SLT:           op = ALU_SLT;
        FN_SLTU:          op = ALU_SLTU;
        default:          op = ALU_ADD;
      endcase
    end else begin
      case (opcode)
        OP_ADDI, OP_ADDIU: op = ALU_ADD;
        OP_SLTI:           op = ALU_SLT;
        OP_SLTIU:          op = ALU_SLTU;
        OP_ANDI:           op = ALU_AND;
        OP_ORI:            op = ALU_OR;
        OP_XORI:           op = ALU_XOR;
        OP_LUI:            op = ALU_LUI;
        OP_BEQ, OP_BNE:    op = ALU_SUB;
        OP_LW, OP_SW:      op = ALU_ADD;
        default:           op = ALU_ADD;
      endcase
    end
  end

  assign alu_op  = ALU_OP_W'(op);
  assign is_div  = category[CAT_DIV];
  assign is_mult = category[CAT_MULT] && !category[CAT_DIV];

endmodule

// File: rtl/mips_control_signal_alu_sequencer.sv
// ID/EX control-word register with valid/ready handshake and a down-counting
// sequencer that holds the slot busy for mult/div before releasing the word.
//
//   state   | meaning
//   IDLE    | accepting decode; output register follows the handshake
//   RUN     | mult/div word parked, counter running down to release
module mips_control_signal_alu_sequencer
  import mips_control_signal_alu_sequencer_pkg::*;
#(
  parameter int OPFUNC_W    = 12,
  parameter int CATEGORY_W  = 8,
  parameter int ALU_OP_W    = 4,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 16,
  parameter int CNT_W       = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OPFUNC_W-1:0]   opFunc,
  input  logic [CATEGORY_W-1:0] category,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            data2_source,
  output logic [ALU_OP_W-1:0]   alu_op,
  output logic                  multi_cycle,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_e                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [1:0]            dec_d2, pend_d2;
  logic [ALU_OP_W-1:0]   dec_alu, pend_alu;
  logic                  dec_mult, dec_div;
  logic                  slot_free, accept, accept_md, done;

  mips_control_signal_alu_decode #(
    .OPFUNC_W   (OPFUNC_W),
    .CATEGORY_W (CATEGORY_W),
    .ALU_OP_W   (ALU_OP_W)
  ) u_decode (
    .opFunc       (opFunc),
    .category     (category),
    .data2_source (dec_d2),
    .alu_op       (dec_alu),
    .is_mult      (dec_mult),
    .is_div       (dec_div)
  );

  assign slot_free = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign accept_md = accept && (dec_mult || dec_div);
  assign done      = (state == ST_RUN) && (cnt == '0) && slot_free;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept_md) state_nxt = ST_RUN;
        ST_RUN:  if (done)      state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      ST_IDLE: in_ready = slot_free;
      ST_RUN:  busy     = 1'b1;
      default: ;
    endcase
  end

  // Output register only changes when the slot is free, so a stalled word holds.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt          <= '0;
      out_valid    <= 1'b0;
      data2_source <= '0;
      alu_op       <= '0;
      multi_cycle  <= 1'b0;
      pend_d2      <= '0;
      pend_alu     <= '0;
    end else if (flush) begin
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept_md) begin
        cnt       <= dec_div ? DIV_LOAD : MULT_LOAD;
        pend_d2   <= dec_d2;
        pend_alu  <= dec_alu;
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid    <= 1'b1;
        data2_source <= dec_d2;
        alu_op       <= dec_alu;
        multi_cycle  <= 1'b0;
      end else if (done) begin
        out_valid    <= 1'b1;
        data2_source <= pend_d2;
        alu_op       <= pend_alu;
        multi_cycle  <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (state == ST_RUN && cnt != '0)
        cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_control_signal_alu_sequencer.sv
// Bench for the ALU control sequencer: directed scenarios plus a randomized
// stream against a timestamp-based model of the handshake and decode tables.
module tb_mips_control_signal_alu_sequencer;

  localparam int MULT_N = 4;
  localparam int DIV_N  = 16;

  localparam logic [11:0] I_SLL  = 12'h000;
  localparam logic [11:0] I_SLLV = 12'h004;
  localparam logic [11:0] I_LW   = 12'h8C0;
  localparam logic [11:0] I_ADDI = 12'h205;
  localparam logic [11:0] I_BEQ  = 12'h100;
  localparam logic [11:0] I_ADD  = 12'h020;
  localparam logic [11:0] I_SUB  = 12'h022;
  localparam logic [11:0] I_MULT = 12'h018;
  localparam logic [11:0] I_DIV  = 12'h01A;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] opFunc = '0;
  logic [7:0]  category = '0;
  logic        in_ready, out_valid, multi_cycle, busy;
  logic [1:0]  data2_source;
  logic [3:0]  alu_op;

  mips_control_signal_alu_sequencer #(
    .OPFUNC_W(12), .CATEGORY_W(8), .ALU_OP_W(4),
    .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(5)
  ) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .opFunc(opFunc), .category(category), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .data2_source(data2_source), .alu_op(alu_op),
    .multi_cycle(multi_cycle), .busy(busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Model: output slot contents plus a parked mult/div word with its issue time.
  bit         m_ov, m_md, m_mc;
  logic [1:0] m_d2, p_d2;
  logic [3:0] m_alu, p_alu;
  int         m_issue, m_n;
  int         funct_alu[int];
  int         op_alu[int];

  function automatic void ref_decode(input logic [11:0] of, input logic [7:0] cat,
                                     output logic [1:0] d2, output logic [3:0] alu,
                                     output int n);
    int opc = int'(of[11:6]);
    int fn  = int'(of[5:0]);
    if (cat[0] && !cat[1])   d2 = 2'd2;
    else if (cat[2] || cat[3]) d2 = 2'd1;
    else if (|cat[7:4])      d2 = 2'd0;
    else                     d2 = 2'd1;
    if (opc == 0) alu = funct_alu.exists(fn) ? 4'(funct_alu[fn]) : 4'd0;
    else          alu = op_alu.exists(opc)   ? 4'(op_alu[opc])   : 4'd0;
    n = cat[7] ? DIV_N : (cat[6] ? MULT_N : 0);
  endfunction

  function automatic bit exp_in_ready();
    return !m_md && (!m_ov || out_ready);
  endfunction

  task automatic model_reset();
    m_ov = 0; m_md = 0; m_mc = 0; m_d2 = '0; m_alu = '0;
  endtask

  task automatic drive(input bit v, input logic [11:0] of, input logic [7:0] cat,
                       input bit ordy, input bit fl);
    in_valid = v; opFunc = of; category = cat; out_ready = ordy; flush = fl;
  endtask

  task automatic tick();
    logic [1:0] d2;
    logic [3:0] alu;
    int n;
    bit sf;
    sf = !m_ov || out_ready;
    ref_decode(opFunc, category, d2, alu, n);
    if (!reset_n) model_reset();
    else if (flush) begin m_ov = 0; m_md = 0; end
    else if (m_md) begin
      if (cyc >= m_issue + m_n && sf) begin
        m_ov = 1; m_md = 0; m_d2 = p_d2; m_alu = p_alu; m_mc = 1;
      end else if (out_ready) m_ov = 0;
    end else if (in_valid && sf) begin
      if (n > 0) begin
        m_md = 1; m_issue = cyc; m_n = n; p_d2 = d2; p_alu = alu; m_ov = 0;
      end else begin
        m_ov = 1; m_d2 = d2; m_alu = alu; m_mc = 0;
      end
    end else if (out_ready) m_ov = 0;
    cyc++;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 0; model_reset();
    drive(1, I_ADD, 8'h10, 1, 0);
    repeat (3) begin
      @(negedge clock); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
      total++; if (data2_source !== 2'd0) begin bad++; $display("FAIL reset_data2: got %0d want 0", data2_source); end
    end
    total++; if (alu_op !== 4'd0 || multi_cycle !== 1'b0) begin bad++; $display("FAIL reset_alu_mc: got alu=%0d mc=%0b want 0 0", alu_op, multi_cycle); end
    reset_n = 1; in_valid = 0; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    tick();
  endtask

  task automatic test_decode();
    logic [11:0] ofs [5] = '{I_SLL, I_SLLV, I_LW, I_ADDI, I_BEQ};
    logic [7:0]  cats[5] = '{8'h11, 8'h13, 8'h04, 8'h00, 8'h20};
    logic [1:0]  d2s [5] = '{2'd2, 2'd0, 2'd1, 2'd1, 2'd0};
    logic [3:0]  alus[5] = '{4'd8, 4'd8, 4'd0, 4'd0, 4'd1};
    for (int i = 0; i < 5; i++) begin
      drive(1, ofs[i], cats[i], 1, 0); #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL decode_in_ready[%0d]: got %0b want 1", i, in_ready); end
      tick();
      drive(0, '0, '0, 1, 0); #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL decode_out_valid[%0d]: got %0b want 1", i, out_valid); end
      total++; if (data2_source !== d2s[i]) begin bad++; $display("FAIL decode_data2[%0d]: got %0d want %0d", i, data2_source, d2s[i]); end
      total++; if (alu_op !== alus[i]) begin bad++; $display("FAIL decode_alu[%0d]: got %0d want %0d", i, alu_op, alus[i]); end
      tick();
    end
  endtask

  task automatic test_mult_back_to_back();
    drive(1, I_MULT, 8'h50, 1, 0); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mult_issue_ready: got %0b want 1", in_ready); end
    tick();
    for (int k = 1; k <= MULT_N; k++) begin
      drive(1, I_ADD, 8'h10, 1, 0); #1;
      total++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
        bad++; $display("FAIL mult_busy_c%0d: got busy=%0b rdy=%0b ov=%0b want 1 0 0", k, busy, in_ready, out_valid); end
      tick();
    end
    #1;
    total++; if (out_valid !== 1'b1 || multi_cycle !== 1'b1) begin bad++; $display("FAIL mult_done: got ov=%0b mc=%0b want 1 1", out_valid, multi_cycle); end
    total++; if (alu_op !== 4'd12 || busy !== 1'b0) begin bad++; $display("FAIL mult_word: got alu=%0d busy=%0b want 12 0", alu_op, busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mult_b2b_ready: got %0b want 1", in_ready); end
    tick();
    drive(0, '0, '0, 1, 0); #1;
    total++; if (out_valid !== 1'b1 || multi_cycle !== 1'b0 || alu_op !== 4'd0) begin
      bad++; $display("FAIL b2b_add: got ov=%0b mc=%0b alu=%0d want 1 0 0", out_valid, multi_cycle, alu_op); end
    tick();
  endtask

  task automatic test_div_stall();
    drive(1, I_DIV, 8'h90, 0, 0);
    tick();
    for (int k = 1; k <= DIV_N; k++) begin
      drive(0, '0, '0, 0, 0); #1;
      total++; if (busy !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL div_busy_c%0d: got busy=%0b ov=%0b want 1 0", k, busy, out_valid); end
      tick();
    end
    #1;
    total++; if (out_valid !== 1'b1 || multi_cycle !== 1'b1 || alu_op !== 4'd14 || busy !== 1'b0) begin
      bad++; $display("FAIL div_done: got ov=%0b mc=%0b alu=%0d busy=%0b want 1 1 14 0", out_valid, multi_cycle, alu_op, busy); end
    for (int k = 0; k < 4; k++) begin
      drive(1, I_ADD, 8'h10, 0, 0); #1;
      total++; if (out_valid !== 1'b1 || alu_op !== 4'd14 || data2_source !== 2'd0 || multi_cycle !== 1'b1 || in_ready !== 1'b0) begin
        bad++; $display("FAIL div_hold_%0d: got ov=%0b alu=%0d d2=%0d mc=%0b rdy=%0b want 1 14 0 1 0", k, out_valid, alu_op, data2_source, multi_cycle, in_ready); end
      tick();
    end
    drive(0, '0, '0, 1, 0);
    tick();
  endtask

  task automatic test_flush();
    drive(1, I_DIV, 8'h90, 1, 0);
    tick();
    drive(0, '0, '0, 1, 0);
    tick(); tick();
    drive(1, I_ADD, 8'h10, 1, 1); #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_pre_busy: got %0b want 1", busy); end
    tick();
    drive(0, '0, '0, 1, 0); #1;
    total++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_after: got busy=%0b ov=%0b rdy=%0b want 0 0 1", busy, out_valid, in_ready); end
    for (int k = 0; k < DIV_N + 4; k++) begin
      tick(); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_emit_%0d: got ov=%0b want 0", k, out_valid); end
    end
    tick();
  endtask

  task automatic test_backpressure();
    drive(1, I_SUB, 8'h10, 1, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1, I_LW, 8'h04, 0, 0); #1;
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_op !== 4'd1 || data2_source !== 2'd0) begin
        bad++; $display("FAIL bp_hold_%0d: got ov=%0b rdy=%0b alu=%0d d2=%0d want 1 0 1 0", k, out_valid, in_ready, alu_op, data2_source); end
      tick();
    end
    drive(1, I_LW, 8'h04, 1, 0); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
    tick();
    drive(0, '0, '0, 1, 0); #1;
    total++; if (out_valid !== 1'b1 || data2_source !== 2'd1 || alu_op !== 4'd0) begin
      bad++; $display("FAIL bp_lw: got ov=%0b d2=%0d alu=%0d want 1 1 0", out_valid, data2_source, alu_op); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    drive(1, I_MULT, 8'h50, 1, 0);
    tick();
    drive(0, '0, '0, 1, 0);
    tick(); tick();
    reset_n = 0; model_reset(); #1;
    total++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL midrun_reset: got busy=%0b ov=%0b rdy=%0b want 0 0 1", busy, out_valid, in_ready); end
    tick();
    reset_n = 1;
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      opFunc    = 12'($urandom);
      if ($urandom_range(0, 1) == 1) opFunc[11:6] = 6'h00;
      category  = 8'($urandom);
      if ($urandom_range(0, 9) < 8) category[7:6] = 2'b00;
      #1;
      total++; if (out_valid !== m_ov) begin bad++; $display("FAIL rnd_out_valid@%0d: got %0b want %0b", cyc, out_valid, m_ov); end
      total++; if (in_ready !== exp_in_ready()) begin bad++; $display("FAIL rnd_in_ready@%0d: got %0b want %0b", cyc, in_ready, exp_in_ready()); end
      total++; if (busy !== m_md) begin bad++; $display("FAIL rnd_busy@%0d: got %0b want %0b", cyc, busy, m_md); end
      if (m_ov) begin
        total++; if (data2_source !== m_d2 || alu_op !== m_alu || multi_cycle !== m_mc) begin
          bad++; $display("FAIL rnd_word@%0d: got d2=%0d alu=%0d mc=%0b want %0d %0d %0b", cyc, data2_source, alu_op, multi_cycle, m_d2, m_alu, m_mc); end
      end
      tick();
    end
    drive(0, '0, '0, 1, 0);
    tick();
  endtask

  initial begin
    funct_alu[0] = 8;  funct_alu[2] = 9;  funct_alu[3] = 10; funct_alu[4] = 8;
    funct_alu[6] = 9;  funct_alu[7] = 10; funct_alu[24] = 12; funct_alu[25] = 13;
    funct_alu[26] = 14; funct_alu[27] = 15; funct_alu[32] = 0; funct_alu[33] = 0;
    funct_alu[34] = 1; funct_alu[35] = 1; funct_alu[36] = 2; funct_alu[37] = 3;
    funct_alu[38] = 4; funct_alu[39] = 5; funct_alu[42] = 6; funct_alu[43] = 7;
    op_alu[8] = 0;  op_alu[9] = 0;  op_alu[10] = 6; op_alu[11] = 7;
    op_alu[12] = 2; op_alu[13] = 3; op_alu[14] = 4; op_alu[15] = 11;
    op_alu[4] = 1;  op_alu[5] = 1;  op_alu[35] = 0; op_alu[43] = 0;
    model_reset();

    test_reset();
    test_decode();
    test_mult_back_to_back();
    test_div_stall();
    test_flush();
    test_backpressure();
    test_reset_mid_run();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
